adder_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that time-shares one N-bit full_adder datapath among NREQ requesters in the input-buffer path.
- Each requester presents operands with a req level. The block grants one requester at a time and registers its operands into the shared adder.
- It returns a registered sum/carry tagged with the requester index.
- It replaces per-channel adders where throughput allows one add every 2 cycles.

---
 rtl/adder_share_arb.sv | 150 +++++++++++++++
 tb/tb_adder_share_arb.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin arbiter that time-shares one N-bit adder
// among NREQ requesters, returning a registered sum tagged with the
// requester index. One operation per two cycles at best.

module full_adder #(
  parameter int unsigned N = 10
) (
  input  logic         r,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N:0]   sum
);

  // Plain N+1-bit add; r forces a zero result.
  always_comb begin
    sum = '0;
    if (!r) begin
      sum = {1'b0, a} + {1'b0, b} + (N+1)'(ci);
    end
  end

endmodule

module adder_share_arb #(
  parameter int unsigned N    = 10,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              r,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] a_bus,
  input  logic [NREQ*N-1:0] b_bus,
  input  logic [NREQ-1:0]   ci_bus,
  output logic [NREQ-1:0]   gnt,
  output logic [N-1:0]      s,
  output logic              co,
  output logic              vld,
  output logic [IDW-1:0]    vid
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ADD  = 1'b1
  } state_t;

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  ptr_d;
  logic [IDW-1:0]  wid_q;
  logic [N-1:0]    opa_q;
  logic [N-1:0]    opb_q;
  logic            opci_q;
  logic [NREQ-1:0] gnt_q;
  logic [N-1:0]    s_q;
  logic            co_q;
  logic            vld_q;
  logic [IDW-1:0]  vid_q;

  logic            found_c;
  logic [IDW-1:0]  win_c;
  int unsigned     idx_c;
  logic [N:0]      sum_c;

  // Rotating priority search: first set req bit starting at ptr, wrapping.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    idx_c   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx_c = 32'(ptr_q) + i;
      if (idx_c >= NREQ) begin
        idx_c = idx_c - NREQ;
      end
      if (!found_c && req[IDW'(idx_c)]) begin
        found_c = 1'b1;
        win_c   = IDW'(idx_c);
      end
    end
  end

  // Pointer moves just past the winner, wrapping at the last requester.
  always_comb begin
    ptr_d = '0;
    if (32'(win_c) != NREQ - 1) begin
      ptr_d = IDW'(32'(win_c) + 1);
    end
  end

  // Shared datapath sees only the captured operands.
  full_adder #(.N(N)) u_fa (
    .r   (1'b0),
    .a   (opa_q),
    .b   (opb_q),
    .ci  (opci_q),
    .sum (sum_c)
  );

  // Arbitration / sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      wid_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      opci_q  <= 1'b0;
      gnt_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      vld_q   <= 1'b0;
      vid_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          vld_q <= 1'b0;
          gnt_q <= '0;
          if (found_c) begin
            opa_q   <= a_bus[32'(win_c)*N +: N];
            opb_q   <= b_bus[32'(win_c)*N +: N];
            opci_q  <= ci_bus[win_c];
            gnt_q   <= NREQ'(1) << win_c;
            wid_q   <= win_c;
            ptr_q   <= ptr_d;
            state_q <= ST_ADD;
          end
        end
        ST_ADD: begin
          gnt_q   <= '0;
          s_q     <= sum_c[N-1:0];
          co_q    <= sum_c[N];
          vid_q   <= wid_q;
          vld_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt = gnt_q;
  assign s   = s_q;
  assign co  = co_q;
  assign vld = vld_q;
  assign vid = vid_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: directed vector table, hand-written corner
// sequences and random traffic, all checked against a cycle model.

module tb_adder_share_arb;

  localparam int unsigned N    = 10;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic              clk = 1'b0;
  logic              r;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] a_bus;
  logic [NREQ*N-1:0] b_bus;
  logic [NREQ-1:0]   ci_bus;
  logic [NREQ-1:0]   gnt;
  logic [N-1:0]      s;
  logic              co;
  logic              vld;
  logic [IDW-1:0]    vid;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_busy, m_ptr, m_w, m_a, m_b, m_ci;
  int m_gnt, m_s, m_co, m_vld, m_vid;

  adder_share_arb #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk    (clk),
    .r      (r),
    .req    (req),
    .a_bus  (a_bus),
    .b_bus  (b_bus),
    .ci_bus (ci_bus),
    .gnt    (gnt),
    .s      (s),
    .co     (co),
    .vld    (vld),
    .vid    (vid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [9:0] a;
    logic [9:0] b;
    logic       ci;
    logic [3:0] exp_gnt;
    int         exp_vid;
    int         exp_s;
    int         exp_co;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the specified behaviour, in plain arithmetic.
  task automatic model_edge();
    int sum, k, found;
    if (r) begin
      m_busy = 0; m_ptr = 0; m_w = 0; m_a = 0; m_b = 0; m_ci = 0;
      m_gnt = 0; m_s = 0; m_co = 0; m_vld = 0; m_vid = 0;
    end else if (m_busy != 0) begin
      sum    = m_a + m_b + m_ci;
      m_s    = sum % 1024;
      m_co   = sum / 1024;
      m_vid  = m_w;
      m_vld  = 1;
      m_gnt  = 0;
      m_busy = 0;
    end else begin
      m_vld = 0;
      m_gnt = 0;
      found = 0;
      for (int i = 0; i < NREQ; i++) begin
        k = (m_ptr + i) % NREQ;
        if (found == 0 && req[k]) begin
          found = 1;
          m_w   = k;
        end
      end
      if (found != 0) begin
        m_a    = int'(a_bus[m_w*N +: N]);
        m_b    = int'(b_bus[m_w*N +: N]);
        m_ci   = int'(ci_bus[m_w]);
        m_gnt  = 1 << m_w;
        m_ptr  = (m_w + 1) % NREQ;
        m_busy = 1;
      end
    end
  endtask

  // Advance one cycle, update the model, then compare every output.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("gnt", int'(gnt), m_gnt);
    chk("vld", int'(vld), m_vld);
    chk("s",   int'(s),   m_s);
    chk("co",  int'(co),  m_co);
    chk("vid", int'(vid), m_vid);
  endtask

  task automatic rand_buses();
    a_bus  = 40'({$urandom(), $urandom()});
    b_bus  = 40'({$urandom(), $urandom()});
    ci_bus = 4'($urandom());
  endtask

  task automatic do_reset();
    r = 1'b1; req = '0;
    step();
    r = 1'b0;
  endtask

  int order[5];

  initial begin
    r = 1'b1; req = '0; a_bus = '0; b_bus = '0; ci_bus = '0;
    step();
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_vld", int'(vld), 0);
    chk("rst_s",   int'(s),   0);
    chk("rst_vid", int'(vid), 0);
    r = 1'b0;

    // sequential directed vectors; ptr carries across entries
    tbl[0] = '{4'b0001, 10'd1023, 10'd1,   1'b0, 4'b0001, 0, 0,   1};
    tbl[1] = '{4'b0100, 10'd300,  10'd200, 1'b1, 4'b0100, 2, 501, 0};
    tbl[2] = '{4'b1001, 10'd5,    10'd6,   1'b0, 4'b1000, 3, 11,  0};
    tbl[3] = '{4'b1001, 10'd512,  10'd512, 1'b1, 4'b0001, 0, 1,   1};
    tbl[4] = '{4'b1111, 10'd1000, 10'd23,  1'b1, 4'b0010, 1, 0,   1};
    tbl[5] = '{4'b1010, 10'd0,    10'd0,   1'b0, 4'b1000, 3, 0,   0};
    for (int i = 0; i < 6; i++) begin
      rand_buses();
      a_bus[tbl[i].exp_vid*N +: N] = tbl[i].a;
      b_bus[tbl[i].exp_vid*N +: N] = tbl[i].b;
      ci_bus[tbl[i].exp_vid]       = tbl[i].ci;
      req = tbl[i].req;
      step();
      chk($sformatf("vec%0d_gnt", i), int'(gnt), int'(tbl[i].exp_gnt));
      req = '0;
      step();
      chk($sformatf("vec%0d_vld", i), int'(vld), 1);
      chk($sformatf("vec%0d_vid", i), int'(vid), tbl[i].exp_vid);
      chk($sformatf("vec%0d_s", i),   int'(s),   tbl[i].exp_s);
      chk($sformatf("vec%0d_co", i),  int'(co),  tbl[i].exp_co);
      step();
      chk($sformatf("vec%0d_vld_drop", i), int'(vld), 0);
    end

    // all four held continuously: strict rotation 0,1,2,3,0
    do_reset();
    for (int k = 0; k < NREQ; k++) begin
      a_bus[k*N +: N] = 10'(100 * k + 7);
      b_bus[k*N +: N] = 10'(11 * k + 1);
      ci_bus[k]       = 1'(k);
    end
    order = '{0, 1, 2, 3, 0};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rr%0d_gnt", k), int'(gnt), 1 << order[k]);
      step();
      chk($sformatf("rr%0d_vid", k), int'(vid), order[k]);
      chk($sformatf("rr%0d_s", k),   int'(s),
          (100 * order[k] + 7) + (11 * order[k] + 1) + (order[k] % 2));
    end
    req = '0;
    step();

    // reset during ADD of requester 1 aborts it and restarts ptr at 0
    do_reset();
    req = 4'b0010;
    step();
    chk("abort_gnt", int'(gnt), 2);
    r = 1'b1; req = '0;
    step();
    chk("abort_vld", int'(vld), 0);
    chk("abort_gnt0", int'(gnt), 0);
    chk("abort_s", int'(s), 0);
    r = 1'b0;
    step();
    chk("abort_novld", int'(vld), 0);
    req = 4'b0110;
    step();
    chk("restart_gnt", int'(gnt), 2);
    req = '0;
    step();
    chk("restart_vid", int'(vid), 1);
    step();

    // operands and req disturbed after sampling do not affect result
    do_reset();
    a_bus[2*N +: N] = 10'd100;
    b_bus[2*N +: N] = 10'd50;
    ci_bus[2]       = 1'b0;
    req = 4'b0100;
    step();
    chk("late_gnt", int'(gnt), 4);
    rand_buses();
    req = 4'b1011;
    step();
    chk("late_s", int'(s), 150);
    chk("late_vid", int'(vid), 2);
    step();
    chk("late_next_gnt", int'(gnt), 8);
    req = '0;
    step();
    step();

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 49) == 0);
      req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom());
      rand_buses();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
